change_dispenser: RTL

- Sequences the vending machine's change-return path.
- Accepts a change amount from vending_machine (its exchange value).
- Pays the amount out with the fewest coins, largest first: 10, then 5, then 1 dollars. Each coin is one handshaked eject to a coin hopper.
- Tracks hopper inventory and refills.
- Reports any amount it could not pay (shortfall) and hopper faults.

---
 rtl/vm_pkg.sv | 12 +
 rtl/hopper_counter.sv | 17 +
 rtl/change_dispenser.sv | 112 +++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: shared vending types: coin denominations with dollar values, change FSM states, drink prices
package vm_pkg;
  typedef enum logic [1:0] {D1 = 2'd0, D5 = 2'd1, D10 = 2'd2, DRSV = 2'd3} denom_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SELECT = 2'd1, S_EJECT = 2'd2, S_DONE = 2'd3} state_e;
  localparam logic [7:0] PRICE_A = 8'd10;
  localparam logic [7:0] PRICE_B = 8'd15;
  localparam logic [7:0] PRICE_C = 8'd20;
  localparam logic [7:0] PRICE_D = 8'd25;
  function automatic logic [7:0] denom_value(input denom_e d);
    return d == D10 ? 8'd10 : d == D5 ? 8'd5 : d == D1 ? 8'd1 : 8'd0;
  endfunction
endpackage

// File: rtl/hopper_counter.sv
// hopper_counter: 8-bit saturating coin count (clk, reset active-low async, dec one coin, inc by amt, cnt out)
module hopper_counter #(
  parameter logic [7:0] INIT = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec,
  input  logic       inc,
  input  logic [7:0] amt,
  output logic [7:0] cnt
);
  logic [8:0] sum;
  always_comb sum = {1'b0, cnt} - {8'd0, dec} + (inc ? {1'b0, amt} : 9'd0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= INIT;
    else cnt <= sum[8] ? 8'hff : sum[7:0];
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 10/5/1 change payout via handshaked ejects; chg_* request in, eject_* hopper handshake, refill_* in, cnt_*/done/shortfall/fault/state out
module change_dispenser
  import vm_pkg::*;
#(
  parameter logic [7:0] INIT_CNT    = 8'd20,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chg_valid,
  input  logic [7:0] chg_amount,
  output logic       chg_ready,
  output logic       eject_valid,
  output logic [1:0] eject_denom,
  input  logic       eject_ack,
  input  logic       refill,
  input  logic [1:0] refill_denom,
  input  logic [7:0] refill_count,
  output logic [7:0] cnt_1,
  output logic [7:0] cnt_5,
  output logic [7:0] cnt_10,
  output logic       done,
  output logic [7:0] shortfall,
  output logic       fault,
  output logic [1:0] state
);
  state_e st, st_nx;
  denom_e den, den_nx, pick;
  logic [7:0] rem, rem_nx, tcnt, tcnt_nx, sf, sf_nx;
  logic flt, flt_nx, f10, f5, f1;
  logic [2:0] dec, inc;
  logic [2:0][7:0] cnt;
  always_comb begin
    f10 = rem >= 8'd10 && cnt[D10] != 8'd0;
    f5 = rem >= 8'd5 && cnt[D5] != 8'd0;
    f1 = rem >= 8'd1 && cnt[D1] != 8'd0;
    pick = f10 ? D10 : f5 ? D5 : D1;
  end
  always_comb begin
    st_nx = st;
    den_nx = den;
    rem_nx = rem;
    tcnt_nx = tcnt;
    sf_nx = sf;
    flt_nx = flt;
    dec = '0;
    case (st)
      S_IDLE:
        if (chg_valid) begin
          rem_nx = chg_amount;
          sf_nx = '0;
          flt_nx = 1'b0;
          st_nx = chg_amount == 8'd0 ? S_DONE : S_SELECT;
        end
      S_SELECT:
        if (f10 | f5 | f1) begin
          st_nx = S_EJECT;
          den_nx = pick;
          tcnt_nx = '0;
        end else begin
          st_nx = S_DONE;
          sf_nx = rem;
        end
      S_EJECT:
        if (eject_ack) begin
          rem_nx = rem - denom_value(den);
          dec = 3'b001 << den;
          st_nx = rem == denom_value(den) ? S_DONE : S_SELECT;
        end else if (tcnt == 8'(ACK_TIMEOUT - 1)) begin
          st_nx = S_DONE;
          flt_nx = 1'b1;
          sf_nx = rem;
        end else begin
          tcnt_nx = tcnt + 8'd1;
        end
      default: st_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= S_IDLE;
      den <= D1;
      rem <= '0;
      tcnt <= '0;
      sf <= '0;
      flt <= 1'b0;
    end else begin
      st <= st_nx;
      den <= den_nx;
      rem <= rem_nx;
      tcnt <= tcnt_nx;
      sf <= sf_nx;
      flt <= flt_nx;
    end
  // the reserved code shifts out of the 3-bit vector, so it refills nothing
  assign inc = refill ? 3'b001 << refill_denom : 3'b000;
  for (genvar i = 0; i < 3; i++) begin : g_hop
    hopper_counter #(.INIT(INIT_CNT)) u_hop (
      .clk(clk), .reset(reset), .dec(dec[i]), .inc(inc[i]), .amt(refill_count), .cnt(cnt[i])
    );
  end
  assign cnt_1 = cnt[D1];
  assign cnt_5 = cnt[D5];
  assign cnt_10 = cnt[D10];
  assign chg_ready = st == S_IDLE;
  assign eject_valid = st == S_EJECT;
  assign done = st == S_DONE;
  assign eject_denom = den;
  assign shortfall = sf;
  assign fault = flt;
  assign state = st;
endmodule
